sram_access_ctrl: RTL

//  Initiator-side controller for the single-port word SRAM (ce/we/addr/sel/data, byte lanes, combinational read,

---
 rtl/sram_ctrl_pkg.sv | 16 +
 rtl/sram_lane_align.sv | 45 ++++
 rtl/sram_access_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM access controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_e;
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

  // Illegal size reports 4 so address arithmetic stays defined; it is rejected anyway.
  function automatic logic [2:0] byte_cnt(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/sram_lane_align.sv
// Combinational lane steering: store sel/data for part 0 (first word) or part 1 (second word),
// and load result extraction from the {hi,lo} word pair with zero/sign extension.
module sram_lane_align
  import sram_ctrl_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic        i_part,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  output logic [3:0]  o_sel,
  output logic [31:0] o_data,
  output logic [31:0] o_rdata
);

  size_e       w_size;
  logic [3:0]  w_mask;
  logic [7:0]  w_mask8;
  logic [63:0] w_wide;
  logic [31:0] w_sh;

  always_comb begin
    w_size = size_e'(i_size);
    case (w_size)
      SZ_B:    w_mask = 4'b0001;
      SZ_H:    w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
    // Lanes spilling past lane 3 land in the upper nibble / upper word and form part 1.
    w_mask8 = {4'b0000, w_mask} << i_off;
    w_wide  = {32'h0, i_wdata} << {i_off, 3'b000};
    o_sel   = i_part ? w_mask8[7:4] : w_mask8[3:0];
    o_data  = i_part ? w_wide[63:32] : w_wide[31:0];

    w_sh = 32'({i_hi, i_lo} >> {i_off, 3'b000});
    case (w_size)
      SZ_B:    o_rdata = {{24{i_signed & w_sh[7]}}, w_sh[7:0]};
      SZ_H:    o_rdata = {{16{i_signed & w_sh[15]}}, w_sh[15:0]};
      default: o_rdata = w_sh;
    endcase
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// Load/store front end for a single-port word SRAM: lane selects, misaligned split into two word
// accesses, load assembly/extension, range and size checking, one response per request.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int MEM_WORDS = 1056,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_sel_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  // Last byte must lie below MEM_WORDS*4; the extra top bit catches wrap past 2^ADDR_W.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS) << 2;

  state_e            r_state;
  logic              r_we;
  logic              r_signed;
  logic              r_err;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_hi;

  logic              w_accept;
  logic              w_reject;
  logic [ADDR_W:0]   w_nm1;
  logic [ADDR_W:0]   w_last;
  logic              w_split;
  logic              w_acc;
  logic [ADDR_W-1:0] w_word0;
  logic [3:0]        w_sel;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] w_rdata;

  assign w_accept = req_valid & req_ready;
  assign w_nm1    = (ADDR_W+1)'(byte_cnt(req_size) - 3'd1);
  assign w_last   = {1'b0, req_addr} + w_nm1;
  assign w_reject = (req_size == SZ_BAD) | (w_last >= LIMIT);
  assign w_split  = ({1'b0, r_addr[1:0]} + byte_cnt(r_size)) > 3'd4;
  assign w_word0  = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_acc    = (r_state == ACC0) | (r_state == ACC1);

  sram_lane_align u_align (
    .i_off    (r_addr[1:0]),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_part   (r_state == ACC1),
    .i_wdata  (r_wdata),
    .i_lo     (r_lo),
    .i_hi     (r_hi),
    .o_sel    (w_sel),
    .o_data   (w_data),
    .o_rdata  (w_rdata)
  );

  assign req_ready  = (r_state == IDLE);
  assign rsp_valid  = (r_state == RESP);
  assign rsp_err    = rsp_valid & r_err;
  assign rsp_rdata  = (rsp_valid && !r_err && !r_we) ? w_rdata : '0;
  assign mem_ce_o   = w_acc;
  assign mem_we_o   = w_acc & r_we;
  assign mem_addr_o = !w_acc ? '0 : (r_state == ACC1) ? w_word0 + ADDR_W'(4) : w_word0;
  assign mem_sel_o  = w_acc ? w_sel : 4'h0;
  assign mem_data_o = w_acc ? w_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= 2'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_we     <= req_we;
          r_signed <= req_signed;
          r_size   <= req_size;
          r_addr   <= req_addr;
          r_wdata  <= req_wdata;
          r_lo     <= '0;
          r_hi     <= '0;
          r_err    <= w_reject;
          r_state  <= w_reject ? RESP : ACC0;
        end
        ACC0: begin
          if (!r_we) r_lo <= mem_data_i;
          r_state <= w_split ? ACC1 : RESP;
        end
        ACC1: begin
          if (!r_we) r_hi <= mem_data_i;
          r_state <= RESP;
        end
        RESP: if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
